// File: rtl/psola_drain_if.sv
// BRAM port bundle between psola_drain and the PSOLA output buffer.
interface psola_drain_if #(
  parameter int unsigned AW = 12
) ();
  logic [AW-1:0]      addr_out;
  logic               wr_en_out;
  logic [31:0]        wr_data_out;
  logic signed [31:0] rd_data_in;

  modport master (
    output addr_out,
    output wr_en_out,
    output wr_data_out,
    input  rd_data_in
  );

  modport slave (
    input  addr_out,
    input  wr_en_out,
    input  wr_data_out,
    output rd_data_in
  );
endinterface

// File: rtl/psola_drain.sv
// Drains the PSOLA overlap-add buffer one sample per audio request, rescaling to sat16.
// Define PSOLA_DRAIN_CLEAR_EN to zero each buffer location after it has been read.
module psola_drain #(
  parameter int unsigned MAX_EXTENDED      = 2200,
  parameter int unsigned FRAC_BITS         = 10,
  parameter int unsigned MAX_EXTENDED_BITS = $clog2(MAX_EXTENDED)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [11:0]        window_len_in,
  input  logic               window_len_valid_in,
  input  logic               audio_req_in,
  psola_drain_if.master      bram,
  output logic signed [15:0] sample_out,
  output logic               sample_valid_out,
  output logic               busy_out,
  output logic               done_out,
  output logic [15:0]        drop_count_out
);
  localparam int unsigned AW = MAX_EXTENDED_BITS;

  typedef enum logic [1:0] {StIdle, StPlay, StRead, StFinish} state_e;

  state_e             state_q, state_d;
  logic               pend_v_q, pend_v_d;
  logic [11:0]        pend_len_q, pend_len_d;
  logic [11:0]        len_q, len_d;
  logic [AW-1:0]      k_q, k_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [1:0]         rd_cnt_q, rd_cnt_d;
  logic signed [15:0] sample_q, sample_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [15:0]        drop_q, drop_d;
  logic               drop_inc;
  logic               last_k;
`ifdef PSOLA_DRAIN_CLEAR_EN
  logic               wr_en_q, wr_en_d;
`endif

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    logic signed [31:0] s;
    s = v >>> FRAC_BITS;
    if (s > 32'sd32767) return 16'sh7fff;
    if (s < -32'sd32768) return 16'sh8000;
    return s[15:0];
  endfunction

  assign last_k = (32'(k_q) + 32'd1) == 32'(len_q);

  always_comb begin
    state_d    = state_q;
    pend_v_d   = pend_v_q;
    pend_len_d = pend_len_q;
    len_d      = len_q;
    k_d        = k_q;
    addr_d     = addr_q;
    rd_cnt_d   = rd_cnt_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    drop_d     = drop_q;
    drop_inc   = 1'b0;
`ifdef PSOLA_DRAIN_CLEAR_EN
    wr_en_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (audio_req_in) begin
          sample_d = '0;
          valid_d  = 1'b1;
          drop_inc = 1'b1;
        end
        if (pend_v_q) begin
          pend_v_d = 1'b0;
          if (pend_len_q != 12'd0) begin
            len_d   = pend_len_q;
            k_d     = '0;
            state_d = StPlay;
          end
        end
      end
      StPlay: begin
        if (audio_req_in) begin
          addr_d   = k_q;
          rd_cnt_d = 2'd0;
          state_d  = StRead;
        end
      end
      StRead: begin
        drop_inc = audio_req_in;
        rd_cnt_d = rd_cnt_q + 2'd1;
`ifdef PSOLA_DRAIN_CLEAR_EN
        // Clear lands in the same cycle the read data is on the bus.
        wr_en_d  = (rd_cnt_q == 2'd1);
`endif
        if (rd_cnt_q == 2'd2) begin
          sample_d = sat16(bram.rd_data_in);
          valid_d  = 1'b1;
          k_d      = k_q + AW'(1);
          state_d  = last_k ? StFinish : StPlay;
        end
      end
      StFinish: begin
        drop_inc = audio_req_in;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (drop_inc && drop_q != 16'hffff) drop_d = drop_q + 16'd1;
    // A fresh strobe wins over consumption in the same cycle.
    if (window_len_valid_in) begin
      pend_v_d   = 1'b1;
      pend_len_d = (window_len_in > 12'(MAX_EXTENDED)) ? 12'(MAX_EXTENDED) : window_len_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      pend_v_q   <= 1'b0;
      pend_len_q <= '0;
      len_q      <= '0;
      k_q        <= '0;
      addr_q     <= '0;
      rd_cnt_q   <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_v_q   <= pend_v_d;
      pend_len_q <= pend_len_d;
      len_q      <= len_d;
      k_q        <= k_d;
      addr_q     <= addr_d;
      rd_cnt_q   <= rd_cnt_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
    end
  end

`ifdef PSOLA_DRAIN_CLEAR_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) wr_en_q <= 1'b0;
    else        wr_en_q <= wr_en_d;
  end
  assign bram.wr_en_out = wr_en_q;
`else
  assign bram.wr_en_out = 1'b0;
`endif

  assign bram.addr_out    = addr_q;
  assign bram.wr_data_out = '0;
  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;
  assign done_out         = done_q;
  assign drop_count_out   = drop_q;
  assign busy_out         = (state_q != StIdle);
endmodule
